// File: rtl/coef_loader_pkg.sv
// Shared types and configuration helpers for the coefficient BRAM loader.
// Lane ratio and legality checks are evaluated at elaboration time by the users of this package.
package coef_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PAD   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int lanes_per_beat(input int data_width, input int bram_width);
        return data_width / bram_width;
    endfunction

    // A beat must split into whole BRAM words and a load must hold whole beats.
    function automatic bit cfg_valid(input int data_width, input int bram_width, input int bram_depth);
        if ((bram_width <= 0) || (data_width < bram_width) || (bram_depth <= 0)) begin
            return 1'b0;
        end else if ((data_width % bram_width) != 0) begin
            return 1'b0;
        end else begin
            return ((bram_depth % (data_width / bram_width)) == 0);
        end
    endfunction

endpackage

// File: rtl/axis_lane_serializer.sv
// Splits one DATA_WIDTH beat into BRAM_WIDTH lanes on a registered output, one lane per cycle.
// o_pending counts the lanes of the current beat still to be shown, including the one on o_data.
module axis_lane_serializer
    import coef_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_WIDTH = 16,
    parameter bit LOW_FIRST  = 1'b1,
    parameter int R          = lanes_per_beat(DATA_WIDTH, BRAM_WIDTH),
    parameter int PW         = $clog2(R + 1)
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pad,
    output logic [BRAM_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [PW-1:0]         o_pending,
    output logic                  o_emit
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [BRAM_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [PW-1:0]         r_pending;

    logic [BRAM_WIDTH-1:0] w_first_lane;
    logic [DATA_WIDTH-1:0] w_load_rest;
    logic [BRAM_WIDTH-1:0] w_next_lane;
    logic [DATA_WIDTH-1:0] w_shift_adv;
    logic                  w_advance;

    assign w_first_lane = LOW_FIRST ? i_data[BRAM_WIDTH-1:0] : i_data[DATA_WIDTH-1 -: BRAM_WIDTH];
    assign w_load_rest  = LOW_FIRST ? (i_data >> BRAM_WIDTH) : (i_data << BRAM_WIDTH);
    assign w_next_lane  = LOW_FIRST ? r_shift[BRAM_WIDTH-1:0] : r_shift[DATA_WIDTH-1 -: BRAM_WIDTH];
    assign w_shift_adv  = LOW_FIRST ? (r_shift >> BRAM_WIDTH) : (r_shift << BRAM_WIDTH);
    assign w_advance    = (r_pending > PW'(1));
    assign o_emit       = i_load | w_advance | i_pad;

    // Output lane register: a new beat preempts nothing because the caller only loads on the last lane.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_pending <= '0;
        end else if (i_load) begin
            r_data    <= w_first_lane;
            r_shift   <= w_load_rest;
            r_pending <= PW'(R);
            r_valid   <= 1'b1;
        end else if (w_advance) begin
            r_data    <= w_next_lane;
            r_shift   <= w_shift_adv;
            r_pending <= r_pending - PW'(1);
            r_valid   <= 1'b1;
        end else if (i_pad) begin
            r_data    <= '0;
            r_pending <= '0;
            r_valid   <= 1'b1;
        end else begin
            r_pending <= '0;
            r_valid   <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_pending = r_pending;

endmodule

// File: rtl/axis_coef_loader.sv
// Streams one AXI-stream coefficient frame into exactly BRAM_DEPTH BRAM writes per load,
// zero-padding short frames and discarding (and flagging) the excess of long ones.
module axis_coef_loader
    import coef_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_WIDTH = 16,
    parameter int BRAM_DEPTH = 1024,
    parameter bit LOW_FIRST  = 1'b1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            cfg_arm,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [BRAM_WIDTH-1:0]           m0_tdata,
    output logic                            m0_tvalid,
    output logic                            busy,
    output logic                            load_done,
    output logic                            overflow,
    output logic [$clog2(BRAM_DEPTH+1)-1:0] word_count
);

    localparam int R     = lanes_per_beat(DATA_WIDTH, BRAM_WIDTH);
    localparam int BEATS = BRAM_DEPTH / R;
    localparam int PW    = $clog2(R + 1);
    localparam int WCW   = $clog2(BRAM_DEPTH + 1);
    localparam int BCW   = $clog2(BEATS + 1);

    if (!cfg_valid(DATA_WIDTH, BRAM_WIDTH, BRAM_DEPTH)) begin : g_bad_cfg
        $error("axis_coef_loader: DATA_WIDTH/BRAM_WIDTH/BRAM_DEPTH combination is not legal");
    end

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;

    state_e         r_state;
    logic           r_busy;
    logic           r_load_done;
    logic           r_overflow;
    logic [WCW-1:0] r_word_count;
    logic [BCW-1:0] r_beats;
    logic           r_last_seen;

    logic [PW-1:0]  w_pending;
    logic           w_emit;
    logic           w_tready;
    logic           w_accept;
    logic           w_load;
    logic           w_pad;
    logic           w_lanes_done;
    logic           w_full;

    // Reset synchroniser: assertion is immediate, release is aligned to aclk.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Lanes are finished once the last one is on the output; the next beat may land on that edge.
    assign w_lanes_done = (w_pending <= PW'(1));
    assign w_full       = (r_word_count == WCW'(BRAM_DEPTH));

    assign w_tready = ((r_state == ST_LOAD) && w_lanes_done && (r_beats < BCW'(BEATS)) && !r_last_seen)
                    || (r_state == ST_DRAIN);
    assign w_accept = s_axis_tvalid & w_tready;
    assign w_load   = w_accept & (r_state == ST_LOAD);

    // Padding starts on the very edge LOAD hands over, so the zero words follow without a gap.
    assign w_pad = ((r_state == ST_PAD) && !w_full)
                || ((r_state == ST_LOAD) && r_last_seen && w_lanes_done && !w_full);

    axis_lane_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BRAM_WIDTH (BRAM_WIDTH),
        .LOW_FIRST  (LOW_FIRST),
        .R          (R),
        .PW         (PW)
    ) u_serializer (
        .aclk      (aclk),
        .rst_n     (w_rst_n),
        .i_load    (w_load),
        .i_data    (s_axis_tdata),
        .i_pad     (w_pad),
        .o_data    (m0_tdata),
        .o_valid   (m0_tvalid),
        .o_pending (w_pending),
        .o_emit    (w_emit)
    );

    // Load sequencing FSM with its counters and status flags.
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
            r_beats      <= '0;
            r_last_seen  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (w_emit) begin
                r_word_count <= r_word_count + WCW'(1);
            end else begin
                r_word_count <= r_word_count;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_arm) begin
                        r_state      <= ST_LOAD;
                        r_busy       <= 1'b1;
                        r_overflow   <= 1'b0;
                        r_word_count <= '0;
                        r_beats      <= '0;
                        r_last_seen  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_load) begin
                        r_beats     <= r_beats + BCW'(1);
                        r_last_seen <= s_axis_tlast;
                    end else if (r_last_seen && w_lanes_done) begin
                        if (w_full) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= ST_PAD;
                        end
                    end else if ((r_beats == BCW'(BEATS)) && w_lanes_done) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_PAD: begin
                    if (w_full) begin
                        r_state     <= ST_DONE;
                        r_load_done <= 1'b1;
                    end else begin
                        r_state <= ST_PAD;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept) begin
                        r_overflow <= 1'b1;
                        if (s_axis_tlast) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = w_tready;
    assign busy          = r_busy;
    assign load_done     = r_load_done;
    assign overflow      = r_overflow;
    assign word_count    = r_word_count;

endmodule

// File: tb/tb_axis_coef_loader.sv
// Directed bench for axis_coef_loader with BRAM_DEPTH=8, R=2: one LOW_FIRST=1 and one LOW_FIRST=0 instance
// share the input stream; only the armed instance ever raises tready.
module tb_axis_coef_loader;

    localparam int DW    = 32;
    localparam int BW    = 16;
    localparam int DEPTH = 8;
    localparam int WCW   = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           aresetn;
    logic           arm1, arm2;
    logic [DW-1:0]  tdata;
    logic           tvalid, tlast;

    logic           rdy1, rdy2, v1, v2, busy1, busy2, done1, done2, ovf1, ovf2;
    logic [BW-1:0]  d1, d2;
    logic [WCW-1:0] wc1, wc2;

    axis_coef_loader #(.DATA_WIDTH(DW), .BRAM_WIDTH(BW), .BRAM_DEPTH(DEPTH), .LOW_FIRST(1'b1)) dut1 (
        .aclk(clk), .aresetn(aresetn), .cfg_arm(arm1),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy1), .s_axis_tlast(tlast),
        .m0_tdata(d1), .m0_tvalid(v1), .busy(busy1), .load_done(done1), .overflow(ovf1), .word_count(wc1)
    );

    axis_coef_loader #(.DATA_WIDTH(DW), .BRAM_WIDTH(BW), .BRAM_DEPTH(DEPTH), .LOW_FIRST(1'b0)) dut2 (
        .aclk(clk), .aresetn(aresetn), .cfg_arm(arm2),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy2), .s_axis_tlast(tlast),
        .m0_tdata(d2), .m0_tvalid(v2), .busy(busy2), .load_done(done2), .overflow(ovf2), .word_count(wc2)
    );

    int checks = 0;
    int errors = 0;
    bit sel    = 1'b0;

    logic           mon_rdy, mon_v, mon_done, mon_busy, mon_ovf;
    logic [BW-1:0]  mon_d;
    logic [WCW-1:0] mon_wc;
    assign mon_rdy  = sel ? rdy2  : rdy1;
    assign mon_v    = sel ? v2    : v1;
    assign mon_done = sel ? done2 : done1;
    assign mon_busy = sel ? busy2 : busy1;
    assign mon_ovf  = sel ? ovf2  : ovf1;
    assign mon_d    = sel ? d2    : d1;
    assign mon_wc   = sel ? wc2   : wc1;

    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [BW-1:0] wq[$];
    int wcyc[$];
    int acc[$];
    logic [DW-1:0] beats [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/accept/done monitor for the selected instance, sampled away from the clock edge.
    always @(negedge clk) begin
        if (mon_v) begin
            wq.push_back(mon_d);
            wcyc.push_back(cyc);
        end
        if (mon_rdy && tvalid) acc.push_back(cyc);
        if (mon_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        acc.delete();
    endtask

    task automatic arm_pulse();
        if (sel) arm2 = 1'b1;
        else     arm1 = 1'b1;
        @(posedge clk); #1;
        arm1 = 1'b0;
        arm2 = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                tvalid = 1'b0;
                @(posedge clk); #1;
            end
            tvalid = 1'b1;
            tdata  = beats[i];
            tlast  = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!mon_rdy && t < 200);
            chk($sformatf("accept_beat%0d", i), mon_rdy, 1'b1);
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_done(output logic ovf_at);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mon_done && t < 300);
        chk("load_done_seen", mon_done, 1'b1);
        ovf_at = mon_ovf;
        @(posedge clk); #1;
    endtask

    initial begin
        logic ovf_at;
        int   base, n, t;
        #400000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ovf_at;
        int   base, n, t;
        aresetn = 1'b0; arm1 = 1'b0; arm2 = 1'b0;
        tvalid  = 1'b0; tlast = 1'b0; tdata = '0;
        repeat (3) @(posedge clk); #1;

        chk("rst_m0_tvalid", v1, 1'b0);
        chk("rst_m0_tdata", d1, 16'h0000);
        chk("rst_tready", rdy1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_load_done", done1, 1'b0);
        chk("rst_overflow", ovf1, 1'b0);
        chk("rst_word_count", wc1, 4'd0);
        aresetn = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("idle_tready", rdy1, 1'b0);

        // Full frame, tvalid held high.
        beats[0] = 32'h0002_0001; beats[1] = 32'h0004_0003;
        beats[2] = 32'h0006_0005; beats[3] = 32'h0008_0007;
        clear_mon(); base = done_cnt;
        arm_pulse();
        chk("t1_busy_after_arm", busy1, 1'b1);
        send_beats(4, 1'b0);
        wait_done(ovf_at);
        chk("t1_overflow", ovf_at, 1'b0);
        chk("t1_nwrites", wq.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_word%0d", i), wq[i], 32'(i + 1));
        chk("t1_contiguous", wcyc[7] - wcyc[0], 7);
        chk("t1_done_latency", done_cyc - wcyc[7], 1);
        chk("t1_accept_spacing", acc[1] - acc[0], 2);
        chk("t1_busy_after_done", busy1, 1'b0);
        chk("t1_word_count", wc1, 4'd8);
        repeat (2) @(posedge clk); #1;
        chk("t1_done_once", done_cnt - base, 1);

        // Short frame: two beats, then four zero pads.
        beats[0] = 32'h0002_0001; beats[1] = 32'h0004_0003;
        clear_mon(); base = done_cnt;
        arm_pulse();
        chk("t2_word_count_cleared", wc1, 4'd0);
        send_beats(2, 1'b0);
        wait_done(ovf_at);
        chk("t2_overflow", ovf_at, 1'b0);
        chk("t2_nwrites", wq.size(), 8);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_word%0d", i), wq[i], 32'(i + 1));
        for (int i = 4; i < 8; i++) chk($sformatf("t2_pad%0d", i), wq[i], 32'h0);
        chk("t2_contiguous", wcyc[7] - wcyc[0], 7);
        chk("t2_done_latency", done_cyc - wcyc[7], 1);
        chk("t2_word_count", wc1, 4'd8);
        repeat (2) @(posedge clk); #1;
        chk("t2_done_once", done_cnt - base, 1);

        // Long frame: six beats, last two dropped.
        beats[0] = 32'h0002_0001; beats[1] = 32'h0004_0003; beats[2] = 32'h0006_0005;
        beats[3] = 32'h0008_0007; beats[4] = 32'h000A_0009; beats[5] = 32'h000C_000B;
        clear_mon();
        arm_pulse();
        send_beats(6, 1'b0);
        wait_done(ovf_at);
        chk("t3_overflow_at_done", ovf_at, 1'b1);
        chk("t3_nwrites", wq.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_word%0d", i), wq[i], 32'(i + 1));
        chk("t3_word_count", wc1, 4'd8);
        chk("t3_overflow_sticky", ovf1, 1'b1);
        arm_pulse();
        chk("t3_overflow_cleared", ovf1, 1'b0);

        // Full frame with random source gaps into the load armed above.
        beats[0] = 32'h0022_0021; beats[1] = 32'h0024_0023;
        beats[2] = 32'h0026_0025; beats[3] = 32'h0028_0027;
        clear_mon();
        send_beats(4, 1'b1);
        wait_done(ovf_at);
        chk("t5_overflow", ovf_at, 1'b0);
        chk("t5_nwrites", wq.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t5_word%0d", i), wq[i], 32'h21 + 32'(i));

        // Most-significant lane first on the second instance.
        sel = 1'b1;
        beats[0] = 32'hAAAA_5555; beats[1] = 32'h2222_1111;
        beats[2] = 32'h4444_3333; beats[3] = 32'h6666_5555;
        clear_mon();
        arm_pulse();
        send_beats(4, 1'b0);
        wait_done(ovf_at);
        chk("t4_nwrites", wq.size(), 8);
        chk("t4_word0", wq[0], 32'hAAAA);
        chk("t4_word1", wq[1], 32'h5555);
        chk("t4_word2", wq[2], 32'h2222);
        chk("t4_word7", wq[7], 32'h5555);
        sel = 1'b0;

        // Reset in the middle of a load.
        clear_mon();
        arm_pulse();
        tvalid = 1'b1; tdata = 32'h0002_0001; tlast = 1'b0;
        n = 0; t = 0;
        while (n < 3 && t < 100) begin
            @(negedge clk);
            if (v1) n++;
            t++;
        end
        chk("t6_writes_before_reset", n, 3);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_m0_tvalid", v1, 1'b0);
        chk("t6_rst_busy", busy1, 1'b0);
        chk("t6_rst_tready", rdy1, 1'b0);
        repeat (2) @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t6_post_busy", busy1, 1'b0);
        chk("t6_post_tready", rdy1, 1'b0);
        chk("t6_post_word_count", wc1, 4'd0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (v1 || rdy1) n++;
        end
        chk("t6_idle_no_activity", n, 0);
        tvalid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_coef_loader.md
Name: axis_coef_loader

Overview:
- Write-side transmitter for the coefficient BRAM port (`s0_tdata`/`s0_tvalid`) of the streaming arithmetic datapath.
- Accepts a coefficient frame from an AXI-stream source (DMA), unpacks each wide beat into BRAM-width words and emits exactly BRAM_DEPTH writes per load.
- Keeps the receiver's free-running write address aligned: short frames are zero-padded, long frames are truncated and flagged.

Parameters:
- DATA_WIDTH, 32: input stream beat width; must be an integer multiple of BRAM_WIDTH.
- BRAM_WIDTH, 16: width of one coefficient word written to BRAM.
- BRAM_DEPTH, 1024: words per load; must be a multiple of R = DATA_WIDTH/BRAM_WIDTH.
- LOW_FIRST, 1: 1 = emit lane 0 (bits BRAM_WIDTH-1:0) first; 0 = emit the most-significant lane first.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `cfg_arm`  in  1  single-cycle pulse that starts one load; ignored while busy.
- `s_axis_tdata`  in  DATA_WIDTH  coefficient beat.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accepted when high with tvalid.
- `s_axis_tlast`  in  1  last beat of the coefficient frame.
- `m0_tdata`  out  BRAM_WIDTH  BRAM write data, registered.
- `m0_tvalid`  out  1  BRAM write strobe, registered; no backpressure.
- `busy`  out  1  high from arm until load_done.
- `load_done`  out  1  one-cycle pulse after the BRAM_DEPTH-th write.
- `overflow`  out  1  sticky; set if the frame exceeds BRAM_DEPTH/R beats; cleared on cfg_arm.
- `word_count`  out  clog2(BRAM_DEPTH+1)  writes issued in the current load.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state = IDLE; all counters 0.
  - `m0_tvalid`, `m0_tdata`, `s_axis_tready`, `busy`, `load_done`, `overflow` all 0.
  - Outputs drop in the same cycle as reset asserts. Reset mid-load aborts the load with no padding; the receiver shares the reset, so alignment holds.
- States:
  - IDLE: tready=0. `cfg_arm` → LOAD; clears `overflow` and `word_count`.
  - LOAD:
    - tready=1 when the serializer holds ≤1 pending lane and beats_accepted < BRAM_DEPTH/R. This gives back-to-back acceptance every R cycles; `m0_tvalid` is continuous while the source keeps up.
    - On accept at cycle t: lanes are driven on `m0_tdata` in cycles t+1..t+R with `m0_tvalid` high; `word_count` increments per emitted word.
    - Accepted beat with tlast → wait for its lanes to finish. If `word_count` == BRAM_DEPTH → DONE, else → PAD.
    - BRAM_DEPTH/R beats accepted, last one without tlast → DRAIN, after the lanes finish emitting.
  - PAD: tready=0; emits `m0_tdata`=0 with `m0_tvalid`=1 every cycle until `word_count` == BRAM_DEPTH, then → DONE.
  - DRAIN: tready=1; `m0_tvalid`=0. Each accepted beat sets `overflow`. Accepted tlast → DONE.
  - DONE: `load_done`=1 for one cycle, `busy`=0 next cycle → IDLE.
- Gaps: if tvalid is low in LOAD, `m0_tvalid` gaps; the receiver tolerates gaps.
- `cfg_arm` while busy: ignored; no effect on `overflow`.
- `busy` = (state != IDLE).
- Handshake: tdata/tlast are sampled only on tvalid&tready. tvalid may rise with no tready dependency.
- `word_count` never exceeds BRAM_DEPTH.
- Exactly BRAM_DEPTH `m0_tvalid` cycles per completed load, under every frame length.

Decomposition:
- Shared package `coef_loader_pkg`:
  - state enum (IDLE, LOAD, PAD, DRAIN, DONE);
  - function computing R;
  - elaboration-time checks (DATA_WIDTH % BRAM_WIDTH == 0, BRAM_DEPTH % R == 0).
- Sub-module `axis_lane_serializer`:
  - loads a DATA_WIDTH word plus a load strobe;
  - shifts out R lanes per LOW_FIRST;
  - reports pending-lane count.
- The top level holds the FSM, counters and flags.

Test Plan (R=2, BRAM_DEPTH=8 unless noted):
- Arm, then 4 beats 0x00020001, 0x00040003, 0x00060005, 0x00080007 (tlast on 4th), tvalid held high → `m0_tdata` 1..8 on 8 consecutive cycles, tready 1-of-2 cycles, `load_done` pulse one cycle after word 8, `overflow`=0.
- Arm, 2 beats 0x00020001, 0x00040003 with tlast on 2nd → words 1,2,3,4 then four zero writes, `word_count`=8, `load_done` pulses once, `overflow`=0.
- Arm, 6 beats, tlast on 6th → words from beats 1–4 written, beats 5–6 accepted and discarded with `m0_tvalid`=0, `overflow`=1 at `load_done`; next `cfg_arm` clears `overflow` to 0.
- LOW_FIRST=0, one full frame with beat 0xAAAA5555 first → first two writes 0xAAAA then 0x5555.
- Random tvalid gaps (50%) on a full frame → 8 writes total, data order preserved, no write while tready low.
- `aresetn` asserted after 3 writes → `m0_tvalid`, `busy`, `s_axis_tready` low in the same cycle; after release, state IDLE, tready=0 until `cfg_arm`.
